// File: rtl/l0_west_feeder.sv
// l0_west_feeder
// Buffers L0 activation/kernel vectors in a FIFO and issues one command at a
// time (kernel load or execute) onto the west edge of the MAC array. Each
// issued vector is row-skewed: row r sees it r cycles after row 0.
// Optional build macro: FEEDER_ZERO_PAD_EN. When defined, an empty FIFO during
// issue produces a zero vector that counts toward the length, and the sticky
// underrun_flag output is added. When undefined, an empty FIFO stalls the
// command with bubbles.
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
// in_ready never depends on in_valid. It is also high when the FIFO is full
// but a pop happens in the same cycle.
// dbg_state exposes the command FSM state (0 idle, 1 issue, 2 drain).

module l0_west_feeder #(
  parameter int bw    = 4,
  parameter int row   = 8,
  parameter int depth = 16,
  parameter int len_w = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [row*bw-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                cmd_start,
  input  logic                cmd_mode,
  input  logic [len_w-1:0]    cmd_len,
  output logic                busy,
  output logic                done,
  output logic [row*bw-1:0]   out_w,
  output logic [row*2-1:0]    inst_out,
`ifdef FEEDER_ZERO_PAD_EN
  output logic                underrun_flag,
`endif
  output logic [1:0]          dbg_state
);

  localparam int aw = $clog2(depth);
  localparam int dw = (row > 1) ? $clog2(row) : 1;
  localparam logic [aw:0]    full_cnt   = (aw+1)'(depth);
  localparam logic [aw:0]    cnt_one    = (aw+1)'(1);
  localparam logic [dw-1:0]  last_drain = dw'(row - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // FIFO storage and pointers
  logic [row*bw-1:0] r_mem [depth];
  logic [aw-1:0]     r_wr_ptr;
  logic [aw-1:0]     r_rd_ptr;
  logic [aw:0]       r_count;

  // Command state
  logic [1:0]        r_state;
  logic              r_mode;
  logic [len_w-1:0]  r_remaining;
  logic [dw-1:0]     r_drain_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic              w_last_issue;
  logic [row*bw-1:0] w_head;
  logic [row*bw-1:0] w_issue_data;
  logic [row*bw-1:0] w_row0_data;
  logic [1:0]        w_row0_inst;

  assign w_full   = (r_count == full_cnt);
  assign w_empty  = (r_count == '0);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_pop    = (r_state == ST_ISSUE) && !w_empty;
  assign in_ready = !reset && (!w_full || w_pop);
  assign w_push   = in_valid && in_ready;

`ifdef FEEDER_ZERO_PAD_EN
  // Every issue cycle emits a vector; an empty FIFO supplies zeros.
  assign w_issue      = (r_state == ST_ISSUE);
  assign w_issue_data = w_empty ? '0 : w_head;
`else
  // Only real FIFO vectors are issued; an empty FIFO yields a bubble.
  assign w_issue      = w_pop;
  assign w_issue_data = w_head;
`endif

  assign w_last_issue = w_issue && (r_remaining == len_w'(1));
  assign w_row0_data  = w_issue ? w_issue_data : '0;
  assign w_row0_inst  = w_issue ? (r_mode ? 2'b10 : 2'b01) : 2'b00;

  assign busy      = (r_state != ST_IDLE);
  assign done      = !reset && (r_state == ST_DRAIN) && (r_drain_cnt == last_drain);
  assign dbg_state = r_state;

  // FIFO pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_one;
        2'b01:   r_count <= r_count - cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset because the pointers gate reads
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  // Command FSM: idle -> issue (len vectors) -> drain (row cycles) -> idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_remaining <= '0;
      r_drain_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_start) begin
            r_mode      <= cmd_mode;
            r_remaining <= cmd_len;
            r_drain_cnt <= '0;
            r_state     <= (cmd_len == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_issue) r_remaining <= r_remaining - len_w'(1);
          if (w_last_issue) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == last_drain) r_state <= ST_IDLE;
          else r_drain_cnt <= r_drain_cnt + dw'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef FEEDER_ZERO_PAD_EN
  logic r_underrun;

  // Sticky underrun indicator, rearmed by each accepted command
  always_ff @(posedge clk) begin
    if (reset) r_underrun <= 1'b0;
    else if ((r_state == ST_IDLE) && cmd_start) r_underrun <= 1'b0;
    else if ((r_state == ST_ISSUE) && w_empty) r_underrun <= 1'b1;
  end

  assign underrun_flag = r_underrun;
`endif

  // Per-row skew lines: row g carries {inst, element} through g+1 stages
  for (genvar g = 0; g < row; g++) begin : g_row
    logic [bw+1:0] r_line [0:g];

    // Shift this row's element and inst code one stage per cycle
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= g; k++) r_line[k] <= '0;
      end else begin
        r_line[0] <= {w_row0_inst, w_row0_data[g*bw +: bw]};
        for (int k = 1; k <= g; k++) r_line[k] <= r_line[k-1];
      end
    end

    assign out_w[g*bw +: bw]   = r_line[g][bw-1:0];
    assign inst_out[2*g +: 2]  = r_line[g][bw+1:bw];
  end

endmodule

// File: tb/tb_l0_west_feeder.sv
// Bench for l0_west_feeder: directed commands against a queue/schedule model
// of the feeder, plus hand-computed latency and value checks.

module tb_l0_west_feeder;
  localparam int BW    = 4;
  localparam int ROW   = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 8;
  localparam int DW    = ROW * BW;
  localparam int IW    = ROW * 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          cmd_start;
  logic          cmd_mode;
  logic [LW-1:0] cmd_len;
  logic          busy;
  logic          done;
  logic [DW-1:0] out_w;
  logic [IW-1:0] inst_out;
  logic [1:0]    dbg_state;
`ifdef FEEDER_ZERO_PAD_EN
  logic          underrun_flag;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: FIFO contents as a queue, future west-edge values keyed by cycle
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sched_w[int];
  logic [IW-1:0] sched_i[int];
  bit m_ok       = 0;
  bit m_active   = 0;
  bit m_issuing  = 0;
  bit m_mode     = 0;
  bit m_flag     = 0;
  int m_remaining = 0;
  int m_done_at   = -1;

  l0_west_feeder #(.bw(BW), .row(ROW), .depth(DEPTH), .len_w(LW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd_start (cmd_start),
    .cmd_mode  (cmd_mode),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .out_w     (out_w),
    .inst_out  (inst_out),
`ifdef FEEDER_ZERO_PAD_EN
    .underrun_flag (underrun_flag),
`endif
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // A vector issued in cycle t shows on row r in cycle t+1+r
  task automatic schedule(input int t, input logic [DW-1:0] v, input logic [1:0] code);
    for (int r = 0; r < ROW; r++) begin
      logic [DW-1:0] w;
      logic [IW-1:0] ii;
      w  = sched_w.exists(t+1+r) ? sched_w[t+1+r] : '0;
      ii = sched_i.exists(t+1+r) ? sched_i[t+1+r] : '0;
      w[r*BW +: BW] = v[r*BW +: BW];
      ii[2*r +: 2]  = code;
      sched_w[t+1+r] = w;
      sched_i[t+1+r] = ii;
    end
  endtask

  // Compare process: check outputs against the model, then advance it
  always @(negedge clk) begin
    logic [DW-1:0] ew;
    logic [IW-1:0] ei;
    logic [1:0]    code;
    bit pop_now;
    bit exp_ready;
    bit was_active;
    if (reset) begin
      check("ready_in_reset", in_ready, 0);
      exp_q.delete();
      sched_w.delete();
      sched_i.delete();
      m_active  = 0;
      m_issuing = 0;
      m_flag    = 0;
      m_ok      = 1;
    end else if (m_ok) begin
      ew = sched_w.exists(cyc) ? sched_w[cyc] : '0;
      ei = sched_i.exists(cyc) ? sched_i[cyc] : '0;
      check("out_w", out_w, ew);
      check("inst_out", inst_out, ei);
      check("busy", busy, m_active);
      check("done", done, m_active && (m_done_at == cyc));
`ifdef FEEDER_ZERO_PAD_EN
      check("underrun_flag", underrun_flag, m_flag);
`endif
      pop_now   = m_issuing && (exp_q.size() > 0);
      exp_ready = (exp_q.size() < DEPTH) || pop_now;
      check("in_ready", in_ready, exp_ready);
      was_active = m_active;
      code = m_mode ? 2'b10 : 2'b01;
      if (m_issuing) begin
        if (exp_q.size() > 0) begin
          schedule(cyc, exp_q.pop_front(), code);
          m_remaining--;
        end
`ifdef FEEDER_ZERO_PAD_EN
        else begin
          schedule(cyc, '0, code);
          m_remaining--;
          m_flag = 1;
        end
`endif
        if (m_remaining == 0) begin
          m_issuing = 0;
          m_done_at = cyc + ROW;
        end
      end
      if (in_valid && exp_ready) exp_q.push_back(in_data);
      if (m_active && (m_done_at == cyc)) m_active = 0;
      if (!was_active && cmd_start) begin
        m_active    = 1;
        m_mode      = cmd_mode;
        m_remaining = cmd_len;
        m_flag      = 0;
        if (cmd_len == 0) m_done_at = cyc + ROW;
        else m_issuing = 1;
      end
      sched_w.delete(cyc);
      sched_i.delete(cyc);
    end
    cyc++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [DW-1:0] v);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check("push_accept", ok, 1);
  endtask

  task automatic start_cmd(input bit mode, input int len);
    cmd_start = 1'b1;
    cmd_mode  = mode;
    cmd_len   = LW'(len);
    tick();
    cmd_start = 1'b0;
  endtask

  // j=1 is the cycle after the call; at=-1 on timeout
  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int j = 1; j <= max && at < 0; j++) begin
      @(negedge clk);
      if (done) at = j;
      tick();
    end
  endtask

  // Directed stimulus
  initial begin
    int at;
    int acc;
    int r0_first, r7_first, r0_cnt, d_at;
    logic [DW-1:0] ew;
    logic [IW-1:0] ei;

    // Test 1: reset held two cycles with in_valid high
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    cmd_start = 1'b0;
    cmd_mode  = 1'b0;
    cmd_len   = '0;
    @(negedge clk);
    check("t1_ready_rst0", in_ready, 0);
    tick();
    @(negedge clk);
    check("t1_ready_rst1", in_ready, 0);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("t1_out_w", out_w, 0);
    check("t1_inst", inst_out, 0);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_ready", in_ready, 1);
    tick();

    // Test 2: kernel load of 8 vectors
    for (int i = 0; i < 8; i++) push_vec(32'h1111_1111 * (i + 1));
    start_cmd(1'b0, 8);
    r0_first = -1; r7_first = -1; r0_cnt = 0; d_at = -1;
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      if (inst_out[1:0] == 2'b01) begin
        r0_cnt++;
        if (r0_first < 0) r0_first = j;
      end
      if (inst_out[15:14] != 2'b00 && r7_first < 0) r7_first = j;
      if (done && d_at < 0) d_at = j;
      tick();
    end
    check("t2_row0_first", r0_first, 2);
    check("t2_row0_count", r0_cnt, 8);
    check("t2_row7_first", r7_first, 9);
    check("t2_done_at", d_at, 16);

    // Test 3: execute skew of one vector; a cmd_start while busy is ignored
    push_vec(32'h7654_3210);
    start_cmd(1'b1, 1);
    for (int j = 1; j <= 12; j++) begin
      cmd_start = (j == 3);
      @(negedge clk);
      ew = '0;
      ei = '0;
      for (int r = 0; r < ROW; r++) begin
        if (j == 2 + r) begin
          ew[r*BW +: BW] = BW'(r);
          ei[2*r +: 2]   = 2'b10;
        end
      end
      check("t3_out_w", out_w, ew);
      check("t3_inst", inst_out, ei);
      check("t3_done", done, j == 9);
      tick();
    end
    cmd_start = 1'b0;

    // Zero-length command: drain only, no inst
    start_cmd(1'b0, 0);
    wait_done(20, at);
    check("len0_done_at", at, 8);

    // Test 4: fill the FIFO, then push+pop while full
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hC0DE_0000 | i;
      @(negedge clk);
      if (in_ready) acc++;
      tick();
    end
    check("t4_accepted", acc, 16);
    cmd_start = 1'b1;
    cmd_mode  = 1'b0;
    cmd_len   = LW'(16);
    @(negedge clk);
    check("t4_full_ready", in_ready, 0);
    tick();
    cmd_start = 1'b0;
    @(negedge clk);
    check("t4_pushpop_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    wait_done(60, at);
    check("t4_done_at", at, 23);
    start_cmd(1'b0, 1);
    wait_done(20, at);
    check("t4_tail_done_at", at, 9);

    // Test 5: underrun with 3 of 5 vectors present
    for (int i = 0; i < 3; i++) push_vec(32'hABCD_0000 | i);
    start_cmd(1'b1, 5);
`ifdef FEEDER_ZERO_PAD_EN
    wait_done(30, at);
    check("t5_done_at", at, 13);
    @(negedge clk);
    check("t5_flag", underrun_flag, 1);
    tick();
`else
    repeat (8) tick();
    @(negedge clk);
    check("t5_busy_stall", busy, 1);
    tick();
    push_vec(32'hABCD_0003);
    push_vec(32'hABCD_0004);
    wait_done(30, at);
    check("t5_done_seen", at > 0, 1);
`endif

    // Test 6: reset during issue aborts, next command runs cleanly
    for (int i = 0; i < 10; i++) push_vec(32'h5A5A_0000 | i);
    start_cmd(1'b0, 10);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_out_w", out_w, 0);
    check("t6_inst", inst_out, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    tick();
    repeat (12) tick();
    push_vec(32'h0F0F_1234);
    push_vec(32'hF0F0_4321);
    start_cmd(1'b1, 2);
    wait_done(20, at);
    check("t6_done_at", at, 10);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
